// File: rtl/mac_tap_engine.sv
// Frame-based FIR multiply-accumulate: TAPS products per frame, scaled result on a valid/ready register.
// Optional output saturation is enabled by defining MAC_SAT_EN; otherwise the result wraps.
module mac_tap_engine #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int GUARD  = 4,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     ARST,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + GUARD;
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(TAPS - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                   state_q, state_d;
  logic [TAP_W-1:0]         tap_idx_q, tap_idx_d;
  logic                     accept, tag_last;

  logic signed [PROD_W-1:0] prod_full, prod_q;
  logic                     prod_v_q, prod_first_q, prod_last_q;

  logic signed [ACC_W-1:0]  acc_q, acc_d, prod_ext, sum, shifted;
  logic                     load;
  logic signed [OUT_W-1:0]  result;

  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ovf_q, ovf_d;

  // Frame sequencing: a first-tagged sample always (re)starts a frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    tap_idx_d = tap_idx_q;
    accept    = 1'b0;
    tag_last  = 1'b0;
    if (in_valid && in_first) begin
      accept    = 1'b1;
      tap_idx_d = TAP_W'(1);
      if (TAPS == 1) begin
        tag_last = 1'b1;
        state_d  = S_IDLE;
      end else begin
        state_d  = S_ACC;
      end
    end else if (in_valid && (state_q == S_ACC)) begin
      accept = 1'b1;
      if (tap_idx_q == LAST_IDX) begin
        tag_last  = 1'b1;
        state_d   = S_IDLE;
        tap_idx_d = '0;
      end else begin
        tap_idx_d = tap_idx_q + TAP_W'(1);
      end
    end
  end

  assign prod_full = PROD_W'(in_data) * PROD_W'(in_coef);

  // Stage 2: a first-tagged product restarts the sum, so an abandoned frame never leaks.
  assign prod_ext = ACC_W'(prod_q);
  assign sum      = prod_first_q ? prod_ext : (acc_q + prod_ext);
  assign acc_d    = prod_v_q ? sum : acc_q;
  assign shifted  = sum >>> SHIFT;
  assign load     = prod_v_q & prod_last_q;

  generate
    if (OUT_W < ACC_W) begin : g_narrow
`ifdef MAC_SAT_EN
      logic [ACC_W-OUT_W:0] top;
      assign top    = shifted[ACC_W-1:OUT_W-1];
      assign result = ((&top) || !(|top)) ? OUT_W'(shifted)
                    : (top[ACC_W-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}});
`else
      assign result = OUT_W'(shifted);
`endif
    end else begin : g_wide
      assign result = OUT_W'(shifted);
    end
  endgenerate

  // A fresh load takes priority over both the consumer handshake and an ovf_clr.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (load) begin
      out_data_d  = result;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q      <= S_IDLE;
      tap_idx_q    <= '0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      prod_first_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_idx_q    <= tap_idx_d;
      if (accept) prod_q <= prod_full;
      prod_v_q     <= accept;
      prod_first_q <= accept & in_first;
      prod_last_q  <= accept & tag_last;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == S_ACC) | prod_v_q;

endmodule
